// File: rtl/output_sram_unloader_pkg.sv
// Shared widths, state encoding and helpers for the output SRAM unload path.
package output_sram_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DEPTH      = 2048;
  localparam int unsigned LAST_ADDR  = 2 * DEPTH - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // True while a stream is in flight; compute-side writes are refused then.
  function automatic logic is_busy(state_e s);
    return (s == S_READ) || (s == S_CAPTURE) || (s == S_PRESENT);
  endfunction

endpackage

// File: rtl/output_sram_unloader_if.sv
// Compute-write, unload-control and serializer handshake bundle.
interface output_sram_unloader_if import output_sram_pkg::*; ();

  logic                  wen;
  logic [ADDR_WIDTH-1:0] wadr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  unload;
  logic                  deq;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  done;
  logic                  wr_drop;

  // Environment side: compute engine plus serializer.
  modport master (
    output wen, wadr, wdata, unload, deq,
    input  out_data, out_valid, done, wr_drop
  );

  // Unloader side.
  modport slave (
    input  wen, wadr, wdata, unload, deq,
    output out_data, out_valid, done, wr_drop
  );

endinterface

// File: rtl/output_sram_unloader_mem.sv
// Two-bank result buffer: one write port, one registered read port.
module output_sram_mem import output_sram_pkg::*; #(
  parameter int unsigned DW  = DATA_WIDTH,
  parameter int unsigned AW  = ADDR_WIDTH,
  parameter int unsigned DEP = DEPTH
) (
  input  logic          clk,
  input  logic          i_wen,
  input  logic [AW-1:0] i_wadr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_ren,
  input  logic [AW-1:0] i_radr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned RW = AW - 1;

  logic [DW-1:0] r_bank0 [DEP];
  logic [DW-1:0] r_bank1 [DEP];
  logic [DW-1:0] r_rd0;
  logic [DW-1:0] r_rd1;
  logic          r_rsel;

  // Write port; address MSB picks the bank.
  always_ff @(posedge clk) begin
    if (i_wen) begin
      if (i_wadr[AW-1]) r_bank1[i_wadr[RW-1:0]] <= i_wdata;
      else              r_bank0[i_wadr[RW-1:0]] <= i_wdata;
    end
  end

  // Read port: both banks read at the row, bank choice remembered for the mux.
  always_ff @(posedge clk) begin
    if (i_ren) begin
      r_rd0  <= r_bank0[i_radr[RW-1:0]];
      r_rd1  <= r_bank1[i_radr[RW-1:0]];
      r_rsel <= i_radr[AW-1];
    end
  end

  assign o_rdata = r_rsel ? r_rd1 : r_rd0;

endmodule

// File: rtl/output_sram_unloader.sv
// Streams the two-bank output buffer, address 0 upward, to the serializer.
module output_sram_unloader import output_sram_pkg::*; (
  input  logic                   clk,
  input  logic                   rst_n,
  output_sram_unloader_if.slave  bus
);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_done;
  logic                  r_wr_drop;

  logic                  w_busy;
  logic                  w_mem_wen;
  logic                  w_mem_ren;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_busy    = is_busy(r_state);
  assign w_mem_wen = bus.wen && !w_busy;
  assign w_mem_ren = (r_state == S_READ);

  output_sram_mem u_mem (
    .clk     (clk),
    .i_wen   (w_mem_wen),
    .i_wadr  (bus.wadr),
    .i_wdata (bus.wdata),
    .i_ren   (w_mem_ren),
    .i_radr  (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Unload FSM with registered presentation, done and sticky write-drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_wr_drop   <= 1'b0;
    end else begin
      if (bus.wen && w_busy) r_wr_drop <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.unload) begin
            r_state  <= S_READ;
            r_rd_ptr <= '0;
          end
        end
        S_READ: begin
          if (!bus.unload) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (!bus.unload) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
          end else begin
            r_out_data  <= w_rdata;
            r_out_valid <= 1'b1;
            r_state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (!bus.unload) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
          end else if (bus.deq) begin
            r_out_valid <= 1'b0;
            if (r_rd_ptr == ADDR_WIDTH'(LAST_ADDR)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
              r_state  <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_out_valid <= 1'b0;
          if (!bus.unload) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;
  assign bus.wr_drop   = r_wr_drop;

endmodule

// File: tb/tb_output_sram_unloader.sv
// Randomized bench for output_sram_unloader against a cycle-level stream model.
module tb_output_sram_unloader;
  import output_sram_pkg::*;

  localparam int NW = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  output_sram_unloader_if bus();

  output_sram_unloader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Behavioural model: stream position, cycles until next word, flags.
  logic [DATA_WIDTH-1:0] m_mem [NW];
  logic                  m_busy  = 1'b0;
  int                    m_wait  = 0;
  int                    m_idx   = 0;
  logic                  m_valid = 1'b0;
  logic [DATA_WIDTH-1:0] m_data  = '0;
  logic                  m_done  = 1'b0;
  logic                  m_drop  = 1'b0;

  int                    cyc = 0;
  logic [DATA_WIDTH-1:0] seen [$];
  int                    done_cycs [$];
  logic                  prev_valid = 1'b0;
  logic                  prev_done  = 1'b0;

  logic [DATA_WIDTH-1:0] ref_data [NW];
  int                    deq_mode = 0;

  // Model update on each edge, compare 1 ns later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_wait = 0; m_idx = 0; m_valid = 0;
        m_data = '0; m_done = 0; m_drop = 0;
      end else begin
        if (bus.wen) begin
          if (m_busy) m_drop = 1'b1;
          else        m_mem[int'(bus.wadr)] = bus.wdata;
        end
        if (m_busy) begin
          if (!bus.unload) begin
            m_busy = 0; m_valid = 0; m_idx = 0;
          end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
              m_valid = 1'b1;
              m_data  = m_mem[m_idx];
            end
          end else if (bus.deq) begin
            m_valid = 1'b0;
            if (m_idx == NW - 1) begin
              m_busy = 0;
              m_done = 1'b1;
            end else begin
              m_idx++;
              m_wait = 2;
            end
          end
        end else if (m_done) begin
          if (!bus.unload) m_done = 1'b0;
        end else if (bus.unload) begin
          m_busy = 1'b1; m_idx = 0; m_wait = 2;
        end
      end
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("done",      32'(bus.done),      32'(m_done));
      check("wr_drop",   32'(bus.wr_drop),   32'(m_drop));
      check("out_data",  32'(bus.out_data),  32'(m_data));
      if (bus.out_valid && !prev_valid) seen.push_back(bus.out_data);
      if (bus.done && !prev_done) done_cycs.push_back(cyc);
      prev_valid = bus.out_valid;
      prev_done  = bus.done;
    end
  end

  // Serializer dequeue: off, tied high, or random pulses.
  initial begin
    bus.deq = 1'b0;
    forever begin
      @(negedge clk);
      bus.deq = (deq_mode == 1) || (deq_mode == 2 && $urandom_range(0, 3) == 0);
    end
  end

  task automatic write_all();
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      bus.wen   = 1'b1;
      bus.wadr  = ADDR_WIDTH'(i);
      bus.wdata = ref_data[i];
    end
    @(negedge clk);
    bus.wen = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (seen.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (seen.size() < n) timeout_fail(name);
  endtask

  task automatic wait_done(input int n0, input int budget, input string name);
    int k = 0;
    while (done_cycs.size() <= n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cycs.size() <= n0) timeout_fail(name);
  endtask

  task automatic stop_stream();
    @(negedge clk);
    bus.unload = 1'b0;
    deq_mode   = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int start;
    int nd;
    int bad;
    rst_n = 1'b0;
    bus.wen = 1'b0; bus.wadr = '0; bus.wdata = '0; bus.unload = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data),  32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_drop",  32'(bus.wr_drop),   32'd0);
    rst_n = 1'b1;

    // Back-to-back with deq tied high, bank boundary markers at 2047/2048.
    for (int i = 0; i < NW; i++) ref_data[i] = DATA_WIDTH'(i);
    ref_data[2047] = 16'hAAAA;
    ref_data[2048] = 16'h5555;
    write_all();
    base = seen.size();
    nd   = done_cycs.size();
    deq_mode = 1;
    @(negedge clk);
    bus.unload = 1'b1;
    start = cyc + 1;
    wait_done(nd, 13000, "b2b_done_timeout");
    if (done_cycs.size() > nd) check("b2b_done_cycles", 32'(done_cycs[nd] - start), 32'd12288);
    check("b2b_words", 32'(seen.size() - base), 32'(NW));
    if (seen.size() >= base + NW) begin
      check("b2b_word3",    32'(seen[base + 3]),    32'h0003);
      check("b2b_bank_lo",  32'(seen[base + 2047]), 32'hAAAA);
      check("b2b_bank_hi",  32'(seen[base + 2048]), 32'h5555);
      check("b2b_last",     32'(seen[base + NW - 1]), 32'h0FFF);
    end
    stop_stream();
    check("b2b_done_clear", 32'(bus.done), 32'd0);

    // Full stream of random data with random dequeue gaps.
    for (int i = 0; i < NW; i++) ref_data[i] = DATA_WIDTH'($urandom);
    write_all();
    base = seen.size();
    nd   = done_cycs.size();
    deq_mode = 2;
    @(negedge clk);
    bus.unload = 1'b1;
    wait_done(nd, 40000, "full_done_timeout");
    check("full_words", 32'(seen.size() - base), 32'(NW));
    if (seen.size() >= base + NW) begin
      bad = 0;
      for (int i = 0; i < NW; i++) if (seen[base + i] !== ref_data[i]) bad++;
      check("full_order_errors", 32'(bad), 32'd0);
    end
    check("full_done", 32'(bus.done), 32'd1);
    stop_stream();

    // Abort while word 100 is presented, then restart from 0.
    base = seen.size();
    deq_mode = 2;
    @(negedge clk);
    bus.unload = 1'b1;
    wait_words(base + 101, 2000, "abort_word100_timeout");
    bus.unload = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_done",  32'(bus.done),      32'd0);
    deq_mode = 0;
    @(negedge clk);
    base = seen.size();
    bus.unload = 1'b1;
    wait_words(base + 1, 20, "restart_timeout");
    if (seen.size() > base) check("restart_word0", 32'(seen[base]), 32'(ref_data[0]));
    stop_stream();

    // Write attempt while presenting is dropped and flagged.
    base = seen.size();
    @(negedge clk);
    bus.unload = 1'b1;
    wait_words(base + 1, 20, "wr_present_timeout");
    bus.wen = 1'b1; bus.wadr = ADDR_WIDTH'(5); bus.wdata = 16'hDEAD;
    @(negedge clk);
    bus.wen = 1'b0;
    check("wr_drop_set", 32'(bus.wr_drop), 32'd1);
    deq_mode = 2;
    repeat (20) @(negedge clk);
    check("wr_drop_sticky", 32'(bus.wr_drop), 32'd1);
    stop_stream();
    base = seen.size();
    deq_mode = 2;
    bus.unload = 1'b1;
    wait_words(base + 6, 200, "wr_reread_timeout");
    if (seen.size() >= base + 6) check("wr_orig_data5", 32'(seen[base + 5]), 32'(ref_data[5]));
    stop_stream();

    // Reset pulse at word 50, then a fresh stream from address 0.
    base = seen.size();
    deq_mode = 2;
    bus.unload = 1'b1;
    wait_words(base + 51, 1000, "rst_word50_timeout");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    check("mid_rst_done",  32'(bus.done),      32'd0);
    check("mid_rst_drop",  32'(bus.wr_drop),   32'd0);
    base = seen.size();
    wait_words(base + 1, 20, "post_rst_timeout");
    if (seen.size() > base) check("post_rst_word0", 32'(seen[base]), 32'(ref_data[0]));
    stop_stream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
